// File: rtl/piso_tx_if.sv
// piso_tx_if: word handshake and serial-side signals of the piso_tx transmitter.
// Signals: din/din_valid (producer -> transmitter), din_ready (transmitter -> producer),
//          so/busy/done (transmitter serial line and frame status).
// Modports: master = word producer, slave = transmitter.
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             so;
    logic             busy;
    logic             done;

    modport master (output din, output din_valid, input din_ready, input so, input busy, input done);
    modport slave  (input din, input din_valid, output din_ready, output so, output busy, output done);
endinterface

// File: rtl/piso_tx.sv
// piso_tx: framed parallel-in/serial-out transmitter (start bit, data MSB-first, optional even parity, stop bit).
// Optional feature: define PISO_TX_PARITY_EN to insert an even-parity bit between the last data bit and stop.
// Ports: clk   - rising-edge clock
//        reset - asynchronous active-low reset
//        bus   - piso_tx_if.slave: din/din_valid in, din_ready (state decode), so/busy/done (registered) out
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    piso_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             so_q, so_d, busy_q, busy_d, done_q, done_d;
    logic             accept;
`ifdef PISO_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bus.din_ready = (state_q == IDLE) || (state_q == STOP);
    assign accept        = bus.din_valid && bus.din_ready;
    assign bus.so        = so_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE, STOP: begin
                // STOP also accepts, giving back-to-back frames with no idle gap
                if (accept) begin
                    state_d = START;
                    shreg_d = bus.din;
`ifdef PISO_TX_PARITY_EN
                    par_d   = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = CW'(WIDTH - 1);
            end
            DATA: begin
                // shreg_q[WIDTH-1] is the bit on so this cycle; fold it into parity as it leaves
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - 1'b1;
`ifdef PISO_TX_PARITY_EN
                par_d   = par_q ^ shreg_q[WIDTH-1];
                if (cnt_q == '0) state_d = PARITY;
`else
                if (cnt_q == '0) state_d = STOP;
`endif
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: state_d = STOP;
`endif
            default: state_d = IDLE;
        endcase
        // outputs are registered, so they are decoded from the state being entered
`ifdef PISO_TX_PARITY_EN
        so_d = (state_d == START)  ? 1'b0 :
               (state_d == DATA)   ? shreg_d[WIDTH-1] :
               (state_d == PARITY) ? par_d : 1'b1;
`else
        so_d = (state_d == START) ? 1'b0 :
               (state_d == DATA)  ? shreg_d[WIDTH-1] : 1'b1;
`endif
        busy_d = state_d != IDLE;
        done_d = state_d == STOP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            so_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PISO_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: self-checking bench for piso_tx; a frame-level model predicts so/busy/done/din_ready each cycle.
module tb_piso_tx;
    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int F = W + 3;
`else
    localparam int F = W + 2;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic frame [$];
    int   pos = -1;

    piso_tx_if #(.WIDTH(W)) bus ();
    piso_tx #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (check %0d)", tag, obs, exp, n_cmp);
        end
    endtask

    function automatic logic m_ready();
        return (pos < 0) || (pos == F - 1);
    endfunction

    // frame = start 0, data MSB-first, optional even parity, stop 1
    task automatic load(input logic [W-1:0] d);
        frame.delete();
        frame.push_back(1'b0);
        for (int i = W - 1; i >= 0; i--) frame.push_back(d[i]);
`ifdef PISO_TX_PARITY_EN
        frame.push_back(^d);
`endif
        frame.push_back(1'b1);
        pos = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".so"},    bus.so,        (pos < 0) ? 1'b1 : frame[pos]);
        chk({tag, ".busy"},  bus.busy,      pos >= 0);
        chk({tag, ".done"},  bus.done,      pos == F - 1);
        chk({tag, ".ready"}, bus.din_ready, m_ready());
    endtask

    task automatic cyc(input string tag, input logic v, input logic [W-1:0] d);
        bus.din_valid = v;
        bus.din       = d;
        @(posedge clk);
        if (reset) begin
            if (v && m_ready()) load(d);
            else if (pos >= 0) pos = (pos == F - 1) ? -1 : pos + 1;
        end
        #1;
        check_outs(tag);
    endtask

    initial begin
        bus.din_valid = 1'b1;
        bus.din       = 8'hA5;
        @(posedge clk);
        #1;
        check_outs("rst");
        for (int i = 0; i < 3; i++) cyc("rst_hold", 1'b1, 8'hA5);
        bus.din_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_outs("rst_rel");

        cyc("a5", 1'b1, 8'hA5);
        for (int i = 0; i < F + 2; i++) cyc("a5", 1'b0, W'($urandom));

        cyc("x01", 1'b1, 8'h01);
        for (int i = 0; i < F + 2; i++) cyc("x01", 1'b0, W'($urandom));

        for (int i = 0; i <= 2 * F + 1; i++)
            cyc("b2b", i < 2 * F, (i < F) ? 8'hFF : 8'h00);

        cyc("stall", 1'b1, W'($urandom));
        for (int i = 1; i <= 2 * F + 1; i++)
            cyc("stall", (i >= 3) && (i <= F), (i < F - 1) ? 8'h3C : 8'hC3);

        cyc("abort", 1'b1, 8'h5A);
        for (int i = 0; i < 4; i++) cyc("abort", 1'b0, W'($urandom));
        reset = 1'b0;
        #1;
        pos = -1;
        check_outs("abort_rst");
        cyc("abort_hold", 1'b1, 8'hFF);
        reset = 1'b1;
        cyc("x81", 1'b1, 8'h81);
        for (int i = 0; i < F + 2; i++) cyc("x81", 1'b0, W'($urandom));

        for (int i = 0; i < 400; i++)
            cyc("rand", $urandom_range(0, 2) != 0, W'($urandom));
        for (int i = 0; i < F + 2; i++) cyc("drain", 1'b0, W'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
